sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter SRAM_AW, default 20, meaning the external SRAM halfword address width.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_if_req, input, 1: instruction-fetch word read request, held until o_if_done.
REQ-005 The block SHALL have port i_if_addr, input, 32: fetch byte address.
REQ-006 The block SHALL have ports o_if_rdata, output, 32, and o_if_done, output, 1: fetch data, valid while done=1.
REQ-007 The block SHALL have port o_if_stall, output, 1: i_if_req & ~o_if_done.
REQ-008 The block SHALL have ports i_dm_read and i_dm_write, input, 1 each: data-port request, held until o_dm_done.
REQ-009 The block SHALL have ports i_dm_addr, input, 32; i_dm_wdata, input, 32; and i_dm_funct3, input, 3 (RV32I load/store width).
REQ-010 The block SHALL have ports o_dm_rdata, output, 32; o_dm_done, output, 1; o_dm_err, output, 1; and o_dm_stall, output, 1 (request & ~done).
REQ-011 The block SHALL have SRAM ports o_SRAM_ADDR, output, SRAM_AW; o_SRAM_DQ, inout, 16; o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, output, 1 each.

Function
REQ-012 The FSM SHALL have states IDLE, LO, HI and RESP.
REQ-013 In IDLE the FSM SHALL arbitrate; a granted request's addr, wdata, funct3 and read/write SHALL be latched, and the FSM SHALL move to LO next cycle.
REQ-014 If both ports request in IDLE, the grant SHALL go to the port not granted last (last_grant register); a single requester SHALL always win.
REQ-015 If i_dm_read and i_dm_write are both 1, the access SHALL be treated as a write.
REQ-016 A misaligned access (word with addr[1:0]!=0, half with addr[0]=1) SHALL skip LO/HI, go IDLE->RESP, perform no SRAM cycle, and assert o_dm_err with o_dm_done.
REQ-017 The SRAM halfword address SHALL be addr[SRAM_AW:1] in LO, and {addr[SRAM_AW:2],1'b1} in HI.
REQ-018 Word accesses SHALL run LO then HI; byte and half accesses SHALL run LO only, then RESP.
REQ-019 Reads SHALL capture o_SRAM_DQ at the rising edge ending LO (low half) and the edge ending HI (high half).
REQ-020 Byte data SHALL be selected by addr[0] (0=bits 7:0); LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-021 During write LO/HI: WE_N=0, OE_N=1, and DQ driven with wdata[15:0] (LO) or wdata[31:16] (HI); SB SHALL drive {wdata[7:0],wdata[7:0]}.
REQ-022 In all other states DQ SHALL be high-Z, WE_N=1 and OE_N=0; CE_N SHALL be constant 0.
REQ-023 LB_N/UB_N SHALL be 0/0 for half and word accesses; for byte accesses LB_N=addr[0] and UB_N=~addr[0]; both SHALL be 1 in IDLE/RESP.
REQ-024 In RESP, the granted port's done SHALL be 1 for exactly one cycle with registered rdata (0 on write/err), and the FSM SHALL return to IDLE.
REQ-025 Latency from request seen in IDLE to done SHALL be 3 cycles for words, 2 for byte/half, and 1 for misaligned.
REQ-026 Request-input changes after grant SHALL NOT affect the access in progress.

Reset
REQ-027 While i_rst_n=0: state=IDLE, last_grant=fetch (data wins first tie), rdata registers 0, done/err 0, WE_N=1, LB_N=UB_N=1, DQ high-Z.
REQ-028 Reset mid-access SHALL abort immediately with no done pulse; WE_N SHALL rise asynchronously.

Verification
REQ-029 LW addr 0x100 with SRAM[0x80]=0x5678, SRAM[0x81]=0x1234 -> o_SRAM_ADDR 0x80 then 0x81; o_dm_rdata=0x12345678 and done on cycle 3.
REQ-030 SB addr 0x203, wdata 0xAB -> one write cycle at address 0x101, LB_N=1, UB_N=0, DQ=0xABAB; done on cycle 2.
REQ-031 LB addr 0x201 with SRAM[0x100]=0x80FF -> rdata 0xFFFFFF80; LBU from the same address -> 0x00000080.
REQ-032 Fetch and data both request from reset -> data granted first, then fetch; repeated simultaneous requests -> grants alternate.
REQ-033 LW addr 0x102 -> o_dm_err=1 and done the next cycle, WE_N stays 1, no SRAM address change required.
REQ-034 Assert i_rst_n=0 during the HI cycle of an SW -> WE_N=1 at once, no done; after release, state is IDLE.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port (fetch/data) arbiter onto a 16-bit async SRAM; words take LO+HI halfword cycles, byte/half take LO only.
// Done follows the request by 3 (word), 2 (byte/half) or 1 (misaligned) cycles; requests are held by the CPU until done.
module sram_arbiter #(
    parameter int SRAM_AW = 20
) (
    input  logic               CLOCK_50,
    input  logic               i_rst_n,
    input  logic               i_if_req,
    input  logic [31:0]        i_if_addr,
    output logic [31:0]        o_if_rdata,
    output logic               o_if_done,
    output logic               o_if_stall,
    input  logic               i_dm_read,
    input  logic               i_dm_write,
    input  logic [31:0]        i_dm_addr,
    input  logic [31:0]        i_dm_wdata,
    input  logic [2:0]         i_dm_funct3,
    output logic [31:0]        o_dm_rdata,
    output logic               o_dm_done,
    output logic               o_dm_err,
    output logic               o_dm_stall,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]        o_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_gnt_dm;
    logic        r_last_dm;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [15:0] r_lo;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    logic        w_dm_req;
    logic        w_any;
    logic        w_sel_dm;
    logic [31:0] w_req_addr;
    logic [2:0]  w_req_f3;
    logic        w_req_misal;
    logic        w_word;
    logic        w_byte;
    logic        w_active;
    logic        w_drive;
    logic [15:0] w_dq_out;
    logic [7:0]  w_rd_byte;
    logic [31:0] w_rd_val;
    logic        w_unused;

    assign w_dm_req   = i_dm_read | i_dm_write;
    assign w_any      = i_if_req | w_dm_req;
    // Tie goes to whichever port did not win last time
    assign w_sel_dm   = w_dm_req & (~i_if_req | ~r_last_dm);
    assign w_req_addr = w_sel_dm ? i_dm_addr : i_if_addr;
    assign w_req_f3   = w_sel_dm ? i_dm_funct3 : 3'b010;

    always_comb begin
        w_req_misal = 1'b0;
        case (w_req_f3[1:0])
            2'b00:   w_req_misal = 1'b0;
            2'b01:   w_req_misal = w_req_addr[0];
            default: w_req_misal = |w_req_addr[1:0];
        endcase
    end

    assign w_word   = r_funct3[1];
    assign w_byte   = (r_funct3[1:0] == 2'b00);
    assign w_active = (r_state == LO) || (r_state == HI);
    assign w_drive  = w_active & r_write;

    always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_any) w_next = w_req_misal ? RESP : LO;
            LO:   w_next = w_word ? HI : RESP;
            HI:   w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_rd_byte = r_addr[0] ? o_SRAM_DQ[15:8] : o_SRAM_DQ[7:0];

    always_comb begin
        w_rd_val = {o_SRAM_DQ, r_lo};
        case (r_funct3[1:0])
            2'b00:   w_rd_val = {{24{~r_funct3[2] & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_rd_val = {{16{~r_funct3[2] & o_SRAM_DQ[15]}}, o_SRAM_DQ};
            default: w_rd_val = {o_SRAM_DQ, r_lo};
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt_dm   <= 1'b0;
            r_last_dm  <= 1'b0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_lo       <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_dm  <= w_sel_dm;
                        r_last_dm <= w_sel_dm;
                        r_write   <= w_sel_dm & i_dm_write;
                        r_err     <= w_req_misal;
                        r_addr    <= w_req_addr;
                        r_wdata   <= i_dm_wdata;
                        r_funct3  <= w_req_f3;
                        // Writes and misaligned accesses respond with zero data
                        if (w_sel_dm) r_dm_rdata <= '0;
                        else          r_if_rdata <= '0;
                    end
                end
                LO: begin
                    if (!r_write) begin
                        if (w_word)        r_lo       <= o_SRAM_DQ;
                        else if (r_gnt_dm) r_dm_rdata <= w_rd_val;
                        else               r_if_rdata <= w_rd_val;
                    end
                end
                HI: begin
                    if (!r_write) begin
                        if (r_gnt_dm) r_dm_rdata <= w_rd_val;
                        else          r_if_rdata <= w_rd_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_dq_out = r_wdata[15:0];
        if (r_state == HI) w_dq_out = r_wdata[31:16];
        else if (w_byte)   w_dq_out = {r_wdata[7:0], r_wdata[7:0]};
    end

    assign o_SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
    assign o_SRAM_ADDR = (r_state == HI) ? {r_addr[SRAM_AW:2], 1'b1} : r_addr[SRAM_AW:1];
    assign o_SRAM_WE_N = ~w_drive;
    assign o_SRAM_OE_N = w_drive;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = w_active ? (w_byte & r_addr[0])  : 1'b1;
    assign o_SRAM_UB_N = w_active ? (w_byte & ~r_addr[0]) : 1'b1;

    assign o_if_done  = (r_state == RESP) & ~r_gnt_dm;
    assign o_dm_done  = (r_state == RESP) & r_gnt_dm;
    assign o_dm_err   = o_dm_done & r_err;
    assign o_if_rdata = r_if_rdata;
    assign o_dm_rdata = r_dm_rdata;
    assign o_if_stall = i_if_req & ~o_if_done;
    assign o_dm_stall = w_dm_req & ~o_dm_done;

    assign w_unused = ^{r_addr[31:SRAM_AW+1]};

endmodule
